// File: rtl/maverickone_wb_arbiter.sv
// Writeback arbiter: shares the register file's single write/unlock port among
// NUM_REQ result buses. Round-robin grant, valid/ready handshake, one registered
// output stage. Writes to x0 are accepted but never enabled.
// Optional: define MAVERICKONE_WB_ARB_PERF_EN to add saturating grant/conflict counters.
module maverickone_wb_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned DW      = 64,
    parameter int unsigned AW      = 6,
    localparam int unsigned IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic [NUM_REQ-1:0][AW-1:0]   req_addr_i,
    input  logic [NUM_REQ-1:0][DW-1:0]   req_data_i,
    input  logic                         hold_i,
    output logic                         wr_unlock_en_o,
    output logic [AW-1:0]                wr_unlock_addr_o,
    output logic [DW-1:0]                wr_unlock_data_o,
    output logic [IW-1:0]                grant_id_o,
`ifdef MAVERICKONE_WB_ARB_PERF_EN
    output logic [NUM_REQ-1:0][31:0]     perf_grants_o,
    output logic [31:0]                  perf_conflicts_o,
`endif
    output logic                         busy_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic          en_q, en_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [IW-1:0] gid_q, gid_d;

    logic [IW-1:0] win_idx;
    logic          win_vld;
    logic          xfer;

    // Round-robin search: first valid requester starting at ptr_q, wrapping.
    always_comb begin
        logic [IW-1:0] cand;
        win_idx = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IW'((32'(ptr_q) + i) % NUM_REQ);
            if (!win_vld && req_valid_i[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // One-hot ready at the winner; suppressed by hold and reset.
    always_comb begin
        req_ready_o = '0;
        if (win_vld && !hold_i && !rst_i) begin
            req_ready_o[win_idx] = 1'b1;
        end
    end

    assign xfer   = win_vld && !hold_i && !rst_i;
    assign busy_o = |(req_valid_i & ~req_ready_o);

    // Next state of pointer and output stage; x0 writes complete with enable low.
    always_comb begin
        ptr_d  = ptr_q;
        en_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        gid_d  = gid_q;
        if (xfer) begin
            ptr_d  = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            en_d   = (req_addr_i[win_idx] != '0);
            addr_d = req_addr_i[win_idx];
            data_d = req_data_i[win_idx];
            gid_d  = win_idx;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q  <= '0;
            en_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            gid_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            en_q   <= en_d;
            addr_q <= addr_d;
            data_q <= data_d;
            gid_q  <= gid_d;
        end
    end

    assign wr_unlock_en_o   = en_q;
    assign wr_unlock_addr_o = addr_q;
    assign wr_unlock_data_o = data_q;
    assign grant_id_o       = gid_q;

`ifdef MAVERICKONE_WB_ARB_PERF_EN
    logic [NUM_REQ-1:0][31:0] perf_grants_q;
    logic [31:0]              perf_conflicts_q;

    // Saturating per-requester grant counters and contention counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_grants_q    <= '0;
            perf_conflicts_q <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (req_valid_i[k] && req_ready_o[k] && (perf_grants_q[k] != '1)) begin
                    perf_grants_q[k] <= perf_grants_q[k] + 32'd1;
                end
            end
            if (xfer && ($countones(req_valid_i) >= 2) && (perf_conflicts_q != '1)) begin
                perf_conflicts_q <= perf_conflicts_q + 32'd1;
            end
        end
    end

    assign perf_grants_o    = perf_grants_q;
    assign perf_conflicts_o = perf_conflicts_q;
`endif

    // Requesters must not withdraw a pending request (reset excepted).
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_valid_chk
        assert property (@(posedge clk_i)
            (!rst_i && req_valid_i[k] && !req_ready_o[k]) |=> (rst_i || req_valid_i[k]));
    end

endmodule

// File: tb/tb_maverickone_wb_arbiter.sv
module tb_maverickone_wb_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 6;
    localparam int unsigned IW = 2;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic [N-1:0]          req_valid_i;
    logic [N-1:0]          req_ready_o;
    logic [N-1:0][AW-1:0]  req_addr_i;
    logic [N-1:0][DW-1:0]  req_data_i;
    logic                  hold_i;
    logic                  wr_unlock_en_o;
    logic [AW-1:0]         wr_unlock_addr_o;
    logic [DW-1:0]         wr_unlock_data_o;
    logic [IW-1:0]         grant_id_o;
    logic                  busy_o;
`ifdef MAVERICKONE_WB_ARB_PERF_EN
    logic [N-1:0][31:0]    perf_grants_o;
    logic [31:0]           perf_conflicts_o;
`endif

    always #5 clk_i = ~clk_i;

    maverickone_wb_arbiter #(.NUM_REQ(N), .DW(DW), .AW(AW)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_addr_i       (req_addr_i),
        .req_data_i       (req_data_i),
        .hold_i           (hold_i),
        .wr_unlock_en_o   (wr_unlock_en_o),
        .wr_unlock_addr_o (wr_unlock_addr_o),
        .wr_unlock_data_o (wr_unlock_data_o),
        .grant_id_o       (grant_id_o),
`ifdef MAVERICKONE_WB_ARB_PERF_EN
        .perf_grants_o    (perf_grants_o),
        .perf_conflicts_o (perf_conflicts_o),
`endif
        .busy_o           (busy_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: what the register-file port should show after the edge.
    int              m_ptr;
    logic            m_en;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_data;
    int              m_gid;

    // Winner = valid requester with the smallest forward distance from the pointer.
    function automatic int winner(logic [N-1:0] v, int ptr);
        int best = -1;
        int bd   = N;
        for (int k = 0; k < N; k++) begin
            if (v[k] && ((k + N - ptr) % N) < bd) begin
                bd   = (k + N - ptr) % N;
                best = k;
            end
        end
        return best;
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r = '0;
        int w = winner(req_valid_i, m_ptr);
        if (!rst_i && !hold_i && w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic model_edge();
        int w = winner(req_valid_i, m_ptr);
        if (rst_i) begin
            m_ptr = 0; m_en = 1'b0; m_addr = '0; m_data = '0; m_gid = 0;
        end else if (!hold_i && w >= 0) begin
            m_en   = (req_addr_i[w] != '0);
            m_addr = req_addr_i[w];
            m_data = req_data_i[w];
            m_gid  = w;
            m_ptr  = (w + 1) % N;
        end else begin
            m_en = 1'b0;
        end
    endtask

    task automatic check_comb(string name, logic [N-1:0] er, logic eb);
        n_vec++;
        if (req_ready_o !== er || busy_o !== eb) begin
            n_err++;
            $display("FAIL %s: ready=%b busy=%b, expected ready=%b busy=%b",
                     name, req_ready_o, busy_o, er, eb);
        end
    endtask

    task automatic check_reg(string name, logic een, logic [AW-1:0] ea, logic [DW-1:0] ed,
                             logic [IW-1:0] eg);
        n_vec++;
        if (wr_unlock_en_o !== een || wr_unlock_addr_o !== ea || wr_unlock_data_o !== ed ||
            grant_id_o !== eg) begin
            n_err++;
            $display("FAIL %s: en=%b addr=%0d data=%h gid=%0d, expected en=%b addr=%0d data=%h gid=%0d",
                     name, wr_unlock_en_o, wr_unlock_addr_o, wr_unlock_data_o, grant_id_o,
                     een, ea, ed, eg);
        end
    endtask

    typedef struct {
        logic          rst;
        logic          hold;
        logic [2:0]    vld;
        logic [5:0]    a0;
        logic [63:0]   d0;
        logic [5:0]    a1;
        logic [63:0]   d1;
        logic [2:0]    rdy;
        logic          busy;
        logic          en;
        logic [5:0]    addr;
        logic [63:0]   data;
        logic [1:0]    gid;
    } vec_t;

    function automatic vec_t mk(logic rst, logic hold, logic [2:0] vld, logic [5:0] a0,
                                logic [63:0] d0, logic [5:0] a1, logic [63:0] d1,
                                logic [2:0] rdy, logic busy, logic en, logic [5:0] addr,
                                logic [63:0] data, logic [1:0] gid);
        vec_t v;
        v.rst = rst; v.hold = hold; v.vld = vld; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
        v.rdy = rdy; v.busy = busy; v.en = en; v.addr = addr; v.data = data; v.gid = gid;
        return v;
    endfunction

    vec_t tv[21];

    logic [N-1:0] prev_vld;
    logic [N-1:0] prev_rdy;
    logic         prev_rst;

    initial begin
        // Requester 2 always drives addr 12 / data 0x102 in the directed phase.
        tv[0]  = mk(1, 0, 3'b111, 10, 64'h100, 11, 64'h101, 3'b000, 1, 0,  0, 64'h0,    0);
        tv[1]  = mk(1, 0, 3'b111, 10, 64'h100, 11, 64'h101, 3'b000, 1, 0,  0, 64'h0,    0);
        tv[2]  = mk(0, 0, 3'b010, 10, 64'h100,  5, 64'hDEAD_BEEF, 3'b010, 0, 1, 5,
                    64'hDEAD_BEEF, 1);
        tv[3]  = mk(1, 0, 3'b000, 10, 64'h100, 11, 64'h101, 3'b000, 0, 0,  0, 64'h0,    0);
        tv[4]  = mk(0, 0, 3'b111, 10, 64'h100, 11, 64'h101, 3'b001, 1, 1, 10, 64'h100,  0);
        tv[5]  = mk(0, 0, 3'b111, 10, 64'h100, 11, 64'h101, 3'b010, 1, 1, 11, 64'h101,  1);
        tv[6]  = mk(0, 0, 3'b111, 10, 64'h100, 11, 64'h101, 3'b100, 1, 1, 12, 64'h102,  2);
        tv[7]  = mk(0, 0, 3'b111, 10, 64'h100, 11, 64'h101, 3'b001, 1, 1, 10, 64'h100,  0);
        tv[8]  = mk(0, 0, 3'b111, 10, 64'h100, 11, 64'h101, 3'b010, 1, 1, 11, 64'h101,  1);
        tv[9]  = mk(0, 0, 3'b111, 10, 64'h100, 11, 64'h101, 3'b100, 1, 1, 12, 64'h102,  2);
        tv[10] = mk(0, 0, 3'b011, 10, 64'h100, 11, 64'h101, 3'b001, 1, 1, 10, 64'h100,  0);
        tv[11] = mk(0, 0, 3'b010, 10, 64'h100, 11, 64'h101, 3'b010, 0, 1, 11, 64'h101,  1);
        tv[12] = mk(0, 1, 3'b101,  0, 64'h1234, 11, 64'h101, 3'b000, 1, 0, 11, 64'h101, 1);
        tv[13] = mk(0, 1, 3'b101,  0, 64'h1234, 11, 64'h101, 3'b000, 1, 0, 11, 64'h101, 1);
        tv[14] = mk(0, 1, 3'b101,  0, 64'h1234, 11, 64'h101, 3'b000, 1, 0, 11, 64'h101, 1);
        tv[15] = mk(0, 0, 3'b101,  0, 64'h1234, 11, 64'h101, 3'b100, 1, 1, 12, 64'h102, 2);
        tv[16] = mk(0, 0, 3'b001,  0, 64'h1234, 11, 64'h101, 3'b001, 0, 0,  0, 64'h1234, 0);
        tv[17] = mk(0, 0, 3'b111, 10, 64'h100, 11, 64'h101, 3'b010, 1, 1, 11, 64'h101,  1);
        tv[18] = mk(1, 0, 3'b101, 10, 64'h100, 11, 64'h101, 3'b000, 1, 0,  0, 64'h0,    0);
        tv[19] = mk(0, 0, 3'b101, 10, 64'h100, 11, 64'h101, 3'b001, 1, 1, 10, 64'h100,  0);
        tv[20] = mk(0, 0, 3'b100, 10, 64'h100, 11, 64'h101, 3'b100, 0, 1, 12, 64'h102,  2);

        rst_i = 1'b1; hold_i = 1'b0; req_valid_i = '0; req_addr_i = '0; req_data_i = '0;
        m_ptr = 0; m_en = 1'b0; m_addr = '0; m_data = '0; m_gid = 0;

        // Directed sequence: constants from the table, model kept in step.
        for (int i = 0; i < 21; i++) begin
            @(negedge clk_i);
            rst_i         = tv[i].rst;
            hold_i        = tv[i].hold;
            req_valid_i   = tv[i].vld;
            req_addr_i[0] = tv[i].a0;
            req_data_i[0] = tv[i].d0;
            req_addr_i[1] = tv[i].a1;
            req_data_i[1] = tv[i].d1;
            req_addr_i[2] = 6'd12;
            req_data_i[2] = 64'h102;
            #1;
            check_comb($sformatf("vec%0d_comb", i), tv[i].rdy, tv[i].busy);
            @(posedge clk_i);
            model_edge();
            #1;
            check_reg($sformatf("vec%0d_out", i), tv[i].en, tv[i].addr, tv[i].data, tv[i].gid);
        end

        // Random phase against the model; pending requests stay stable.
        prev_vld = req_valid_i;
        prev_rdy = req_ready_o;
        prev_rst = rst_i;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk_i);
            for (int k = 0; k < N; k++) begin
                if (!(prev_vld[k] && !prev_rdy[k] && !prev_rst)) begin
                    req_valid_i[k] = ($urandom_range(0, 99) < 65);
                    req_addr_i[k]  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
                    req_data_i[k]  = {$urandom, $urandom};
                end
            end
            hold_i = ($urandom_range(0, 99) < 20);
            rst_i  = ($urandom_range(0, 99) < 3);
            #1;
            check_comb($sformatf("rnd%0d_comb", c), model_ready(), |(req_valid_i & ~model_ready()));
            prev_vld = req_valid_i;
            prev_rdy = model_ready();
            prev_rst = rst_i;
            @(posedge clk_i);
            model_edge();
            #1;
            check_reg($sformatf("rnd%0d_out", c), m_en, m_addr, m_data, IW'(m_gid));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/maverickone_wb_arbiter.md
Name: maverickone_wb_arbiter

Overview:
- Shares the register file's single write/unlock port among NUM_REQ writeback requesters (e.g. ALU, LSU, MUL/DIV).
- Arbitration is round-robin with per-requester valid/ready handshakes. The winner is registered onto the write-unlock bus, which drives the register file's write-unlock address, data and enable inputs.
- Sits between the execution-unit result buses and the register file.

Parameters:
- NUM_REQ, 3, number of writeback requesters (>=1).
- DW, 64, data width (equals the package XLEN).
- AW, 6, register address width (equals $clog2 of the package NUM_REGS).
- IW, max(1,$clog2(NUM_REQ)), width of the grant index (localparam).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- req_valid_i  in  NUM_REQ  per-requester write request valid.
- req_ready_o  out  NUM_REQ  per-requester grant/ready (at most one bit set).
- req_addr_i  in  NUM_REQ x AW  per-requester destination register address.
- req_data_i  in  NUM_REQ x DW  per-requester write data.
- hold_i  in  1  pipeline hold; blocks all grants while high.
- wr_unlock_en_o  out  1  registered write/unlock enable to the register file.
- wr_unlock_addr_o  out  AW  registered write address.
- wr_unlock_data_o  out  DW  registered write data.
- grant_id_o  out  IW  index of the requester whose write is currently on the output.
- busy_o  out  1  high when any req_valid_i is set but not accepted this cycle.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - ptr=0, wr_unlock_en_o=0, wr_unlock_addr_o=0, wr_unlock_data_o=0, grant_id_o=0.
  - req_ready_o is forced to 0 combinationally while rst_i=1, so no handshake completes during reset.
- Arbitration (combinational):
  - The winner is the first k with req_valid_i[k]=1, searching ptr, ptr+1, ... wrapping modulo NUM_REQ.
  - req_ready_o is one-hot at the winner when !hold_i && !rst_i; otherwise it is all zero.
  - req_ready_o does not depend on any other requester's ready.
- Handshake: a transfer occurs when req_valid_i[k] && req_ready_o[k]. Requester obligations:
  - Once valid is raised, hold valid, addr and data stable until ready.
  - Never deassert valid without a transfer (simulation assertion).
- Output stage, one-cycle latency (transfer in cycle N, outputs in cycle N+1):
  - If transfer from k: wr_unlock_en_o <= (req_addr_i[k]!=0); addr_o <= req_addr_i[k]; data_o <= req_data_i[k]; grant_id_o <= k.
  - If no transfer: wr_unlock_en_o <= 0; addr_o, data_o and grant_id_o hold their values.
- Address 0: the request is accepted (ready returned) but en_o stays 0, so x0 is never written.
- Pointer: after a transfer from k, ptr <= (k+1) mod NUM_REQ. With no transfer, ptr holds. Wrap from NUM_REQ-1 goes to 0.
- hold_i=1: no transfers; en_o is 0 on the next cycle; ptr is frozen; pending requests stay pending. busy_o=1 if any valid is set.
- Simultaneous requests to the same address: serialized in round-robin order, so the last granted write wins in the register file.
- Throughput: one write per cycle when requests are continuously available.
- Fairness bound: a requester with valid held high is granted within NUM_REQ cycles of hold_i being low.
- NUM_REQ=1: ptr is constant 0; the requester is granted whenever valid && !hold_i.

Optional Feature:
- Macro: MAVERICKONE_WB_ARB_PERF_EN.
- When defined, adds:
  - output perf_grants_o (NUM_REQ x 32): per-requester transfer counters.
  - output perf_conflicts_o (32): counts cycles with >=2 valid requests and a transfer.
  - All counters clear on rst_i, saturate at 2^32-1 and never wrap.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold rst_i=1 for 2 cycles with all valid=1 -> ready=0; en_o=0; addr_o=0; data_o=0; grant_id_o=0.
- Single write: req1 valid with addr=5, data=0xDEAD_BEEF -> ready[1]=1 same cycle; next cycle en_o=1, addr_o=5, data_o=0xDEAD_BEEF, grant_id_o=1.
- Round-robin: all 3 valid continuously from reset for 6 cycles -> grant order 0,1,2,0,1,2; en_o=1 every cycle after the first.
- hold_i: hold_i=1 for 3 cycles while req2 is valid -> ready=0, en_o=0, busy_o=1. Release -> req2 granted in the first cycle, and ptr is unchanged from its pre-hold value.
- x0 write: req0 addr=0, data=0x1234 -> ready[0]=1; next cycle en_o=0 and ptr advances to 1.
- Reset mid-operation: rst_i=1 in the same cycle req0 and req2 are valid -> no ready. After reset, req0 is granted first (ptr=0).
